// File: rtl/sha256_iter.sv
// sha256_iter: iterative multi-block SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock.
// Define SHA224_MODE_EN to add the mode_224 input (SHA-224 IV and truncated digest).
module sha256_iter #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
`ifdef SHA224_MODE_EN
   input  logic         mode_224,
`endif
   output logic [255:0] hashed
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
      $error("sha256_iter: ROUNDS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                     32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
   localparam logic [5:0] STEP     = 6'(ROUNDS_PER_CYCLE);
   localparam logic [5:0] LAST_CNT = 6'(64 - ROUNDS_PER_CYCLE);

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   state_t       state_reg;
   logic [255:0] h_reg;
   logic [255:0] work_reg;
   logic [255:0] hashed_reg;
   logic [511:0] win_reg;
   logic [5:0]   cnt_reg;
   logic         last_reg;
   logic         first_reg;
   logic         in_ready_reg;
   logic         out_valid_reg;
   logic [255:0] h_sum;
   logic [255:0] digest;
   logic [255:0] iv_sel;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Slides the 16-word window forward by ROUNDS_PER_CYCLE words; later new words may
   // depend on earlier new words in the same cycle, hence the local extension array.
   function automatic logic [511:0] next_window(input logic [511:0] win);
      logic [31:0]  ext [20];
      logic [511:0] res;
      for (int i = 0; i < 16; i++) ext[i] = win[511-32*i -: 32];
      for (int i = 16; i < 20; i++) ext[i] = '0;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
         ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
      res = '0;
      for (int i = 0; i < 16; i++) res[511-32*i -: 32] = ext[i+ROUNDS_PER_CYCLE];
      return res;
   endfunction

   function automatic logic [255:0] do_rounds(input logic [255:0] s, input logic [5:0] t,
                                              input logic [511:0] win);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      logic [5:0]  idx;
      {a, b, c, d, e, f, g, h} = s;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         idx = t + 6'(j);
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
              + K[idx] + win[511-32*j -: 32];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g;
         g = f;
         f = e;
         e = d + t1;
         d = c;
         c = b;
         b = a;
         a = t1 + t2;
      end
      return {a, b, c, d, e, f, g, h};
   endfunction

   for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
      assign h_sum[255-32*gi -: 32] = h_reg[255-32*gi -: 32] + work_reg[255-32*gi -: 32];
   end

`ifdef SHA224_MODE_EN
   logic mode_reg;
   assign iv_sel = mode_224 ? IV224 : IV256;
   assign digest = mode_reg ? {h_sum[255:32], 32'h0} : h_sum;
`else
   assign iv_sel = IV256;
   assign digest = h_sum;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         h_reg         <= IV256;
         work_reg      <= '0;
         win_reg       <= '0;
         cnt_reg       <= '0;
         last_reg      <= 1'b0;
         first_reg     <= 1'b1;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         hashed_reg    <= '0;
`ifdef SHA224_MODE_EN
         mode_reg      <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready_reg) begin
                  win_reg      <= in_block;
                  cnt_reg      <= '0;
                  last_reg     <= in_last;
                  in_ready_reg <= 1'b0;
                  first_reg    <= 1'b0;
                  state_reg    <= ROUND;
                  // First block of a message starts from the selected IV, later blocks chain.
                  if (first_reg) begin
                     h_reg    <= iv_sel;
                     work_reg <= iv_sel;
`ifdef SHA224_MODE_EN
                     mode_reg <= mode_224;
`endif
                  end else begin
                     work_reg <= h_reg;
                  end
               end
            end
            ROUND: begin
               work_reg <= do_rounds(work_reg, cnt_reg, win_reg);
               win_reg  <= next_window(win_reg);
               cnt_reg  <= cnt_reg + STEP;
               if (cnt_reg == LAST_CNT) state_reg <= FINAL;
            end
            FINAL: begin
               h_reg <= h_sum;
               if (last_reg) begin
                  hashed_reg    <= digest;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  in_ready_reg <= 1'b1;
                  state_reg    <= IDLE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  h_reg         <= IV256;
                  first_reg     <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign hashed    = hashed_reg;

endmodule

// File: tb/tb_sha256_iter.sv
// Bench for sha256_iter: drives R=1,2,4 instances in lockstep, checks digests against
// known vectors and a full-W-array SHA-256 reference model on random messages.
module tb_sha256_iter;

   localparam int RS [3] = '{1, 2, 4};
   localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                     32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [511:0] in_block = '0;
   logic         in_last = 1'b0;
   logic         out_ready = 1'b0;
   logic [2:0]   in_ready;
   logic [2:0]   out_valid;
   logic [255:0] hashed [3];
`ifdef SHA224_MODE_EN
   logic         mode_224 = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   logic [7:0]   msgq [$];
   logic [511:0] blkq [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      sha256_iter #(.ROUNDS_PER_CYCLE(RS[gi])) u_dut (
         .clk      (clk),
         .reset    (reset),
         .in_valid (in_valid),
         .in_ready (in_ready[gi]),
         .in_block (in_block),
         .in_last  (in_last),
         .out_valid(out_valid[gi]),
         .out_ready(out_ready),
`ifdef SHA224_MODE_EN
         .mode_224 (mode_224),
`endif
         .hashed   (hashed[gi])
      );
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook compression: full 64-entry message schedule, then 64 rounds.
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      logic [255:0] res;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return res;
   endfunction

   function automatic logic [255:0] model_digest(input logic m224);
      logic [255:0] h;
      h = m224 ? IV224 : IV256;
      for (int k = 0; k < blkq.size(); k++) h = compress(h, blkq[k]);
      if (m224) h[31:0] = 32'h0;
      return h;
   endfunction

   task automatic load_str(input string s);
      msgq.delete();
      for (int i = 0; i < s.len(); i++) msgq.push_back(s[i]);
   endtask

   task automatic load_rand(input int len);
      msgq.delete();
      for (int i = 0; i < len; i++) msgq.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic pad_msg();
      logic [7:0]  b [$];
      logic [63:0] bits;
      logic [511:0] blk;
      b = msgq;
      bits = 64'(msgq.size()) * 64'd8;
      b.push_back(8'h80);
      while (b.size() % 64 != 56) b.push_back(8'h00);
      for (int i = 7; i >= 0; i--) b.push_back(bits[8*i +: 8]);
      blkq.delete();
      for (int k = 0; k < b.size() / 64; k++) begin
         for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = b[64*k+j];
         blkq.push_back(blk);
      end
   endtask

   task automatic send_block(input string tag, input logic [511:0] blk, input logic last);
      in_block = blk;
      in_last  = last;
      in_valid = 1'b1;
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) in_block[32*i +: 32] = $urandom();
      check({tag, "_ready_drop"}, 256'(in_ready), 256'(3'b000));
   endtask

   task automatic wait_digest(input string tag, input logic [255:0] exp, input int hold);
      logic [2:0] seen;
      int lat [3];
      int n;
      seen = '0;
      lat = '{0, 0, 0};
      n = 0;
      while (seen != 3'b111 && n < 400) begin
         for (int i = 0; i < 3; i++)
            if (!seen[i] && out_valid[i]) begin
               seen[i] = 1'b1;
               lat[i] = cyc - acc_cyc + 1;
            end
         if (seen != 3'b111) begin @(posedge clk); #1; n++; end
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_lat_r%0d", tag, RS[i]), 256'(lat[i]), 256'(64 / RS[i] + 2));
         check($sformatf("%s_digest_r%0d", tag, RS[i]), hashed[i], exp);
      end
      for (int c = 0; c < hold; c++) begin
         @(posedge clk); #1;
         check($sformatf("%s_hold_valid_c%0d", tag, c), 256'(out_valid), 256'(3'b111));
         check($sformatf("%s_hold_ready_c%0d", tag, c), 256'(in_ready), 256'(3'b000));
         for (int i = 0; i < 3; i++)
            check($sformatf("%s_hold_hash_r%0d", tag, RS[i]), hashed[i], exp);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_clear"}, 256'(out_valid), 256'(3'b000));
      check({tag, "_ready_back"}, 256'(in_ready), 256'(3'b111));
      for (int i = 0; i < 3; i++)
         check($sformatf("%s_keep_hash_r%0d", tag, RS[i]), hashed[i], exp);
   endtask

   task automatic run_msg(input string tag, input logic [255:0] exp, input int hold, input int gap);
      int n;
      logic saw;
      for (int b = 0; b < blkq.size(); b++) begin
         if (b > 0) repeat (gap) begin @(posedge clk); #1; end
         send_block(tag, blkq[b], 1'(b == blkq.size() - 1));
         if (b != blkq.size() - 1) begin
            n = 0;
            saw = 1'b0;
            while (in_ready !== 3'b111 && n < 400) begin
               @(posedge clk); #1;
               n++;
               if (out_valid != 3'b000) saw = 1'b1;
            end
            check($sformatf("%s_idle_b%0d", tag, b), 256'(n < 400), 256'(1));
            check($sformatf("%s_nodigest_b%0d", tag, b), 256'(saw), 256'(0));
         end else begin
            wait_digest(tag, exp, hold);
         end
      end
      $display("msg %s blocks=%0d digest=%h", tag, blkq.size(), hashed[0]);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_ready", 256'(in_ready), 256'(3'b111));
      check("reset_valid", 256'(out_valid), 256'(3'b000));
      for (int i = 0; i < 3; i++) check($sformatf("reset_hash_r%0d", RS[i]), hashed[i], 256'h0);

      load_str("abc"); pad_msg();
      run_msg("abc", D_ABC, 0, 0);

      load_str(""); pad_msg();
      run_msg("empty", D_EMPTY, 10, 0);

      load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"); pad_msg();
      run_msg("two", D_TWO, 0, 5);

      // Reset in the middle of the first block's rounds; no chaining residue may survive.
      send_block("rst_mid", blkq[0], 1'b0);
      repeat (29) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid_ready", 256'(in_ready), 256'(3'b111));
      check("rst_mid_valid", 256'(out_valid), 256'(3'b000));
      for (int i = 0; i < 3; i++) check($sformatf("rst_mid_hash_r%0d", RS[i]), hashed[i], 256'h0);
      load_str("abc"); pad_msg();
      run_msg("abc_after_rst", D_ABC, 0, 0);

      for (int r = 0; r < 5; r++) begin
         load_rand($urandom_range(0, 130));
         pad_msg();
         run_msg($sformatf("rand%0d_len%0d", r, msgq.size()), model_digest(1'b0), 0, $urandom_range(0, 3));
      end

`ifdef SHA224_MODE_EN
      mode_224 = 1'b1;
      load_str("abc"); pad_msg();
      run_msg("abc224", {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, 0, 0);
      mode_224 = 1'b0;
      run_msg("abc_after224", D_ABC, 0, 0);
      mode_224 = 1'b1;
      load_rand(100); pad_msg();
      run_msg("rand224", model_digest(1'b1), 0, 2);
      mode_224 = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
